// File: rtl/exec_unit_scheduler.sv
// Sequences the multi-cycle DIV/REM unit and FPALU beside the EX stage: issues start pulses,
// stalls the pipeline until the result is ready, drains units orphaned by a flush.
module exec_unit_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iValid,
    input  logic iIsDivRem,
    input  logic iIsFPALU,
    input  logic iFlush,
    input  logic iDivReady,
    input  logic iFPALUReady,
    output logic oDivStart,
    output logic oFPALUStart,
    output logic oStall,
    output logic oResultValid,
    output logic oResultSel,
    output logic oBusy,
    output logic oTimeout
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StDone,
        StDrain
    } stateT;

    stateT            stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic             unitSelQ, unitSelD;
    logic             timeoutQ, timeoutD;

    logic req;
    logic selReady;
    logic cntExpired;

    assign req        = iValid & (iIsDivRem | iIsFPALU);
    // unitSel: 0 = DIV/REM, 1 = FPALU
    assign selReady   = unitSelQ ? iFPALUReady : iDivReady;
    assign cntExpired = (cntQ == CNT_W'(TIMEOUT_CYCLES - 1));

    assign oBusy    = (stateQ != StIdle);
    assign oTimeout = timeoutQ;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            stateQ   <= StIdle;
            cntQ     <= '0;
            unitSelQ <= 1'b0;
            timeoutQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            unitSelQ <= unitSelD;
            timeoutQ <= timeoutD;
        end
    end

    always_comb begin
        stateD       = stateQ;
        cntD         = cntQ;
        unitSelD     = unitSelQ;
        timeoutD     = timeoutQ;
        oDivStart    = 1'b0;
        oFPALUStart  = 1'b0;
        oStall       = 1'b0;
        oResultValid = 1'b0;
        oResultSel   = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (req && !iFlush) begin
                    stateD   = StIssue;
                    unitSelD = ~iIsDivRem;
                    oStall   = 1'b1;
                end
            end
            StIssue: begin
                if (iFlush) begin
                    stateD = StIdle;
                end else begin
                    oStall      = 1'b1;
                    oDivStart   = ~unitSelQ;
                    oFPALUStart = unitSelQ;
                    stateD      = StWait;
                    cntD        = '0;
                end
            end
            StWait: begin
                if (iFlush) begin
                    // A result arriving with the flush is simply dropped; nothing left to drain.
                    stateD = selReady ? StIdle : StDrain;
                    cntD   = '0;
                end else begin
                    oStall = 1'b1;
                    if (selReady) begin
                        stateD = StDone;
                    end else if (cntExpired) begin
                        timeoutD = 1'b1;
                        stateD   = StDone;
                    end else begin
                        cntD = cntQ + CNT_W'(1);
                    end
                end
            end
            StDone: begin
                oResultValid = ~iFlush;
                oResultSel   = ~iFlush & unitSelQ;
                stateD       = StIdle;
            end
            StDrain: begin
                oStall = req & ~iFlush;
                if (selReady) begin
                    stateD = StIdle;
                end else if (cntExpired) begin
                    timeoutD = 1'b1;
                    stateD   = StIdle;
                end else begin
                    cntD = cntQ + CNT_W'(1);
                end
            end
            default: stateD = StIdle;
        endcase
    end

endmodule

// File: tb/tb_exec_unit_scheduler.sv
// Directed table-driven bench for exec_unit_scheduler (TIMEOUT_CYCLES = 8).
module tb_exec_unit_scheduler;

    logic clk = 1'b0;
    logic rst, valid, isDiv, isFp, flush, divRdy, fpRdy;
    logic divStart, fpStart, stall, resValid, resSel, busy, tmo;

    int nCmp = 0;
    int nErr = 0;

    // Input vector order:  {rst, valid, isDiv, isFp, flush, divRdy, fpRdy}
    // Output vector order: {divStart, fpStart, stall, resValid, resSel, busy, tmo}
    typedef struct {
        logic [6:0] in;
        logic [6:0] exp;
    } vecT;

    vecT vecs[34];

    exec_unit_scheduler #(
        .TIMEOUT_CYCLES(8),
        .CNT_W         (4)
    ) dut (
        .iCLK        (clk),
        .iRST        (rst),
        .iValid      (valid),
        .iIsDivRem   (isDiv),
        .iIsFPALU    (isFp),
        .iFlush      (flush),
        .iDivReady   (divRdy),
        .iFPALUReady (fpRdy),
        .oDivStart   (divStart),
        .oFPALUStart (fpStart),
        .oStall      (stall),
        .oResultValid(resValid),
        .oResultSel  (resSel),
        .oBusy       (busy),
        .oTimeout    (tmo)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic [6:0] in);
        {rst, valid, isDiv, isFp, flush, divRdy, fpRdy} = in;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [6:0] in, input logic [6:0] exp, input string name);
        logic [6:0] got;
        {rst, valid, isDiv, isFp, flush, divRdy, fpRdy} = in;
        @(negedge clk);
        got = {divStart, fpStart, stall, resValid, resSel, busy, tmo};
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %b want %b (in %b)", name, got, exp, in);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // DIV request, ready rises 5 cycles later
        vecs[0]  = '{7'b0000000, 7'b0000000};
        vecs[1]  = '{7'b0110000, 7'b0010000};
        vecs[2]  = '{7'b0110000, 7'b1010010};
        vecs[3]  = '{7'b0110000, 7'b0010010};
        vecs[4]  = '{7'b0110000, 7'b0010010};
        vecs[5]  = '{7'b0110000, 7'b0010010};
        vecs[6]  = '{7'b0110010, 7'b0010010};
        vecs[7]  = '{7'b0110010, 7'b0001010};
        vecs[8]  = '{7'b0000000, 7'b0000000};
        // FPALU with ready already high: ignored in ISSUE, sampled first WAIT cycle
        vecs[9]  = '{7'b0101001, 7'b0010000};
        vecs[10] = '{7'b0101001, 7'b0110010};
        vecs[11] = '{7'b0101001, 7'b0010010};
        vecs[12] = '{7'b0101001, 7'b0001110};
        vecs[13] = '{7'b0000000, 7'b0000000};
        // Both flags: DIV wins, FPALU ready is not the selected one
        vecs[14] = '{7'b0111000, 7'b0010000};
        vecs[15] = '{7'b0111000, 7'b1010010};
        vecs[16] = '{7'b0111001, 7'b0010010};
        vecs[17] = '{7'b0111011, 7'b0010010};
        vecs[18] = '{7'b0111011, 7'b0001010};
        vecs[19] = '{7'b0000000, 7'b0000000};
        // Flush in IDLE
        vecs[20] = '{7'b0110100, 7'b0000000};
        vecs[21] = '{7'b0000000, 7'b0000000};
        // Flush in ISSUE
        vecs[22] = '{7'b0101000, 7'b0010000};
        vecs[23] = '{7'b0101100, 7'b0000010};
        vecs[24] = '{7'b0000000, 7'b0000000};
        // Flush in DONE
        vecs[25] = '{7'b0110000, 7'b0010000};
        vecs[26] = '{7'b0110000, 7'b1010010};
        vecs[27] = '{7'b0110010, 7'b0010010};
        vecs[28] = '{7'b0110110, 7'b0000010};
        vecs[29] = '{7'b0000000, 7'b0000000};
        // Ready together with flush in WAIT goes straight to IDLE
        vecs[30] = '{7'b0101000, 7'b0010000};
        vecs[31] = '{7'b0101000, 7'b0110010};
        vecs[32] = '{7'b0101101, 7'b0000010};
        vecs[33] = '{7'b0000000, 7'b0000000};

        {rst, valid, isDiv, isFp, flush, divRdy, fpRdy} = 7'b1000000;
        @(posedge clk);
        @(posedge clk);
        #1;

        for (int i = 0; i < 34; i++) begin
            cyc(vecs[i].in, vecs[i].exp, $sformatf("tbl[%0d]", i));
        end

        // Flush in WAIT orphans DIV; a new FPALU op waits in DRAIN until DIV answers
        cyc(7'b0110000, 7'b0010000, "drain req");
        cyc(7'b0110000, 7'b1010010, "drain divstart");
        cyc(7'b0110000, 7'b0010010, "drain wait");
        cyc(7'b0110100, 7'b0000010, "drain flush");
        for (int i = 0; i < 4; i++) begin
            cyc(7'b0101000, 7'b0010010, $sformatf("drain hold%0d", i));
        end
        cyc(7'b0101010, 7'b0010010, "drain divready");
        cyc(7'b0101000, 7'b0010000, "drain release");
        cyc(7'b0101000, 7'b0110010, "drain fpstart");
        cyc(7'b0101001, 7'b0010010, "drain fpwait");
        cyc(7'b0101001, 7'b0001110, "drain fpdone");
        cyc(7'b0000000, 7'b0000000, "drain idle");

        // Unit never answers: timeout after 8 WAIT cycles, one garbage result, sticky flag
        cyc(7'b0110000, 7'b0010000, "tmo req");
        cyc(7'b0110000, 7'b1010010, "tmo start");
        for (int i = 0; i < 8; i++) begin
            cyc(7'b0110000, 7'b0010010, $sformatf("tmo wait%0d", i));
        end
        cyc(7'b0110000, 7'b0001011, "tmo done");
        for (int i = 0; i < 3; i++) begin
            cyc(7'b0000000, 7'b0000001, $sformatf("tmo sticky%0d", i));
        end

        // Reset in WAIT clears everything, including the sticky timeout
        cyc(7'b0101000, 7'b0010001, "rst req");
        cyc(7'b0101000, 7'b0110011, "rst start");
        cyc(7'b0101000, 7'b0010011, "rst wait");
        tick(7'b1101000);
        cyc(7'b0000001, 7'b0000000, "rst cleared");
        cyc(7'b0000001, 7'b0000000, "rst ready ignored");
        cyc(7'b0000000, 7'b0000000, "rst idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
